branch_predict_ctrl: RTL and testbench
======================================

// Module: branch_predict_ctrl
// PURPOSE
//  Branch prediction and misprediction-recovery controller for the pipelined femtoRV32 core.
//  IF stage: looks up a 2-bit saturating-counter branch history table (BHT) indexed by PC.
//  EX stage: compares the branch unit's taken/not-taken result with the carried prediction
//   and trains the BHT.
//  On a mismatch it sequences a fixed-length pipeline flush and a PC redirect.
// PARAMETERS
//  BHT_ENTRIES   16  number of BHT entries; power of 2, 2..256
//  FLUSH_CYCLES  2   cycles flush is held (kills IF/ID and ID/EX); 1..7
// PORTS
//  clk               in   1   single core clock; all state updates on rising edge
//  rst               in   1   synchronous reset, active-high
//  if_valid          in   1   IF stage holds a valid fetch
//  if_pc             in   32  fetch PC
//  pred_taken        out  1   combinational prediction for if_pc (counter[1]); 0 if !if_valid
//  ex_valid          in   1   EX stage holds a valid instruction
//  ex_is_branch      in   1   EX instruction is a conditional branch
//  ex_pc             in   32  PC of EX instruction
//  ex_pred_taken     in   1   prediction made for it in IF, carried down the pipe
//  ex_branch_taken   in   1   resolved outcome from the branch unit
//  ex_target         in   32  computed branch target
//  flush             out  1   kill younger instructions; registered
//  redirect_valid    out  1   one-cycle pulse: load redirect_pc into PC; registered
//  redirect_pc       out  32  correct next PC; registered
//  busy              out  1   1 while FSM is in FLUSH
//  stat_branches     out  32  resolved-branch count (see CONFIGURATION)
//  stat_mispredicts  out  32  misprediction count (see CONFIGURATION)
// BEHAVIOUR
//  Index: idx = pc[IDX_W+1:2], IDX_W = $clog2(BHT_ENTRIES). No tags; aliasing is permitted.
//  Counter coding:
//   - 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//   - Taken: +1, saturating at 11. Not taken: -1, saturating at 00.
//  Reset (rst=1 at edge):
//   - All counters <= 01.
//   - FSM <= IDLE.
//   - flush = redirect_valid = busy = 0; redirect_pc = 0.
//   - Stats = 0.
//   - rst overrides any in-progress flush, which is abandoned immediately.
//  resolve = ex_valid & ex_is_branch & (state==IDLE)
//  mispredict = resolve & (ex_branch_taken != ex_pred_taken)
//  IDLE:
//   - On resolve, counter[idx(ex_pc)] is updated at the edge.
//   - On mispredict, next edge:
//     - state <= FLUSH, flush <= 1, redirect_valid <= 1, busy <= 1.
//     - redirect_pc <= ex_branch_taken ? ex_target : ex_pc + 4 (32-bit wrap).
//     - cnt <= FLUSH_CYCLES - 1.
//  FLUSH:
//   - flush stays 1; redirect_valid is 0 after its first cycle.
//   - cnt decrements each cycle. At cnt==0, next edge: state <= IDLE, flush <= 0, busy <= 0.
//   - EX inputs are ignored (those instructions are being killed): no BHT update, no stat count.
//  Latency:
//   - Mispredict detected in cycle N.
//   - flush/redirect asserted in cycle N+1.
//   - flush deasserted in cycle N+1+FLUSH_CYCLES.
//  Correct prediction: no flush; BHT updated only; zero penalty.
//  Same-index read/write in one cycle: pred_taken returns the pre-update (old) counter.
//  if_valid=0: pred_taken=0; the table is not affected.
//  ex_is_branch=0 or ex_valid=0: no action.
// CONFIGURATION
//  BP_STATS_EN defined:
//   - stat_branches increments on every resolve.
//   - stat_mispredicts increments on every mispredict.
//   - Both saturate at 32'hFFFF_FFFF; both are cleared by rst.
//  BP_STATS_EN undefined: both ports are tied to 32'h0 and no counter flops are inferred.
// TESTING
//  1. Reset, then lookup any PC -> pred_taken=0 (counter 01). Flush and redirect stay 0.
//  2. Branch at 0x100 resolved taken twice, both predicted 0:
//     - First: mispredict, flush high 2 cycles, redirect_pc=ex_target.
//     - Second: counter 10 -> 11; lookup 0x100 gives pred_taken=1.
//  3. Predicted taken, resolved not taken at ex_pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap).
//  4. Second mispredicting branch presented during FLUSH:
//     - No extra redirect and no BHT change.
//     - flush drops exactly FLUSH_CYCLES cycles after the first.
//  5. Same idx updated and looked up in one cycle -> pred_taken shows the old value;
//     the new value is visible the next cycle.
//  6. rst asserted mid-FLUSH -> flush and busy are 0 the next cycle and the BHT returns to 01.
//     With BP_STATS_EN: 3 branches, 1 mispredict give stats 3/1.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: 2-bit BHT prediction with mispredict flush/redirect FSM; define BP_STATS_EN for branch/mispredict counters
module branch_predict_ctrl #(
   parameter int BHT_ENTRIES  = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic        ex_pred_taken,
   input  logic        ex_branch_taken,
   input  logic [31:0] ex_target,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);
   typedef enum logic {IDLE, FLUSH} state_t;
   state_t state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic [1:0] bht [BHT_ENTRIES];
   logic [IDX_W-1:0] if_idx, ex_idx;
   logic resolve, mispredict, flush_nxt, redirect_valid_nxt;
   logic [31:0] redirect_pc_nxt;
   logic unused_pc;
   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign unused_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0]};
   assign resolve = ex_valid & ex_is_branch & (state == IDLE);
   assign mispredict = resolve & (ex_branch_taken != ex_pred_taken);
   assign pred_taken = if_valid & bht[if_idx][1];
   assign busy = (state == FLUSH);
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      end else if (resolve) begin
         bht[ex_idx] <= ex_branch_taken ? (bht[ex_idx] == 2'b11 ? 2'b11 : bht[ex_idx] + 2'd1)
                                        : (bht[ex_idx] == 2'b00 ? 2'b00 : bht[ex_idx] - 2'd1);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         flush          <= flush_nxt;
         redirect_valid <= redirect_valid_nxt;
         redirect_pc    <= redirect_pc_nxt;
      end
   end
   // cnt is reloaded every IDLE cycle, so its value only matters inside FLUSH
   always_comb begin
      state_nxt = (state == IDLE) ? (mispredict ? FLUSH : IDLE) : (cnt == 3'd0 ? IDLE : FLUSH);
      cnt_nxt   = (state == IDLE) ? 3'(FLUSH_CYCLES - 1) : cnt - 3'd1;
   end
   always_comb begin
      flush_nxt          = (state_nxt == FLUSH);
      redirect_valid_nxt = mispredict;
      redirect_pc_nxt    = mispredict ? (ex_branch_taken ? ex_target : ex_pc + 32'd4) : redirect_pc;
   end
`ifdef BP_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (resolve && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
         if (mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`else
   assign stat_branches    = '0;
   assign stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed checks of prediction, training, flush/redirect timing and stats
module tb_branch_predict_ctrl;
`ifdef BP_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic if_valid = 1'b0, ex_valid = 1'b0, ex_is_branch = 1'b0, ex_pred_taken = 1'b0, ex_branch_taken = 1'b0;
   logic [31:0] if_pc = '0, ex_pc = '0, ex_target = '0;
   logic pred_taken, flush, redirect_valid, busy;
   logic [31:0] redirect_pc, stat_branches, stat_mispredicts;
   int checks = 0, failures = 0;
   branch_predict_ctrl #(.BHT_ENTRIES(16), .FLUSH_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
      .ex_branch_taken(ex_branch_taken), .ex_target(ex_target), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic ex_set(input logic v, input logic [31:0] pc, input logic p, input logic t, input logic [31:0] tgt);
      ex_valid = v; ex_is_branch = v; ex_pc = pc; ex_pred_taken = p; ex_branch_taken = t; ex_target = tgt;
   endtask
   task automatic ctl(input string tag, input logic f, input logic rv, input logic b);
      chk({tag, "_flush"}, {31'b0, flush}, {31'b0, f});
      chk({tag, "_rv"}, {31'b0, redirect_valid}, {31'b0, rv});
      chk({tag, "_busy"}, {31'b0, busy}, {31'b0, b});
   endtask
   task automatic lookup(input string tag, input logic [31:0] pc, input logic v, input logic exp);
      if_pc = pc; if_valid = v;
      #1;
      chk(tag, {31'b0, pred_taken}, {31'b0, exp});
   endtask
   task automatic stats(input string tag, input int b, input int m);
      chk({tag, "_br"}, stat_branches, STATS ? b : 0);
      chk({tag, "_mp"}, stat_mispredicts, STATS ? m : 0);
   endtask
   initial begin
      tick(); tick();
      rst = 1'b0;
      ctl("reset", 0, 0, 0);
      chk("reset_rpc", redirect_pc, 32'h0);
      stats("reset", 0, 0);
      lookup("reset_pred", 32'h100, 1, 0);
      // first taken resolve at 0x100: mispredict, counter 01->10
      ex_set(1, 32'h100, 0, 1, 32'h200);
      tick();
      ex_set(0, 0, 0, 0, 0);
      ctl("mp1_c1", 1, 1, 1);
      chk("mp1_rpc", redirect_pc, 32'h200);
      tick();
      ctl("mp1_c2", 1, 0, 1);
      tick();
      ctl("mp1_c3", 0, 0, 0);
      lookup("after_mp1", 32'h100, 1, 1);
      // second taken resolve, carried prediction 0: counter 10->11
      ex_set(1, 32'h100, 0, 1, 32'h200);
      tick();
      ex_set(0, 0, 0, 0, 0);
      ctl("mp2_c1", 1, 1, 1);
      tick(); tick();
      ctl("mp2_c3", 0, 0, 0);
      lookup("pred_0x100", 32'h100, 1, 1);
      lookup("pred_invalid", 32'h100, 0, 0);
      stats("after_mp2", 2, 2);
      // predicted taken, resolved not-taken at top of memory: pc+4 wraps
      ex_set(1, 32'hFFFF_FFFC, 1, 0, 32'h40);
      tick();
      ex_set(0, 0, 0, 0, 0);
      ctl("wrap_c1", 1, 1, 1);
      chk("wrap_rpc", redirect_pc, 32'h0);
      tick(); tick();
      ctl("wrap_c3", 0, 0, 0);
      // mispredict followed by another mispredict held during FLUSH
      ex_set(1, 32'h104, 0, 1, 32'h300);
      tick();
      ex_set(1, 32'h108, 0, 1, 32'h500);
      ctl("ign_c1", 1, 1, 1);
      chk("ign_rpc1", redirect_pc, 32'h300);
      tick();
      ctl("ign_c2", 1, 0, 1);
      chk("ign_rpc2", redirect_pc, 32'h300);
      tick();
      ex_set(0, 0, 0, 0, 0);
      ctl("ign_c3", 0, 0, 0);
      lookup("ign_bht", 32'h108, 1, 0);
      stats("after_ign", 4, 4);
      // same-index update and lookup: old value now, new value next cycle
      ex_set(1, 32'h10C, 1, 1, 32'h600);
      lookup("same_old", 32'h10C, 1, 0);
      tick();
      ex_set(0, 0, 0, 0, 0);
      ctl("same_noflush", 0, 0, 0);
      lookup("same_new", 32'h10C, 1, 1);
      stats("after_same", 5, 4);
      // reset in the middle of a flush
      ex_set(1, 32'h100, 1, 0, 32'h700);
      tick();
      ex_set(0, 0, 0, 0, 0);
      ctl("pre_rst", 1, 1, 1);
      chk("nt_rpc", redirect_pc, 32'h104);
      stats("pre_rst", 6, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ctl("mid_rst", 0, 0, 0);
      chk("mid_rst_rpc", redirect_pc, 32'h0);
      stats("mid_rst", 0, 0);
      lookup("rst_bht0", 32'h100, 1, 0);
      lookup("rst_bht3", 32'h10C, 1, 0);
      // three branches, the last mispredicted
      ex_set(1, 32'h200, 0, 0, 32'h0);
      tick();
      ex_set(1, 32'h204, 0, 0, 32'h0);
      tick();
      ex_set(1, 32'h208, 1, 0, 32'h0);
      tick();
      ex_set(0, 0, 0, 0, 0);
      ctl("last_c1", 1, 1, 1);
      chk("last_rpc", redirect_pc, 32'h20C);
      tick(); tick();
      ctl("last_c3", 0, 0, 0);
      stats("final", 3, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
